// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller: state names,
// opcodes, datapath mux selects and the decoded control bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_BLT    = 4'd9,
    S_ADDIEX = 4'd10,
    S_IMMEX  = 4'd11,
    S_IMMWB  = 4'd12,
    S_JUMP   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LI    = 6'b010001;
  localparam logic [5:0] OP_BLT   = 6'b011111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_RS   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  localparam logic [2:0] SRCB_B        = 3'b000;
  localparam logic [2:0] SRCB_FOUR     = 3'b001;
  localparam logic [2:0] SRCB_SIMM     = 3'b010;
  localparam logic [2:0] SRCB_SIMM_SH2 = 3'b011;
  localparam logic [2:0] SRCB_IMM_HI   = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       branch;
    logic       blt;
    logic [1:0] alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Combinational decode of controller state into datapath controls. Only IMMEX
// (immediate source) and DECODE (illegal flag) look at the opcode.
module mc_outdec
  import mc_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  op_i,
  output ctrl_t       ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.alusrca = SRCA_PC;
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.pcsrc   = PCSRC_ALU;
        ctrl_o.irwrite = 1'b1;
        ctrl_o.pcwrite = 1'b1;
      end
      S_DECODE: begin
        // Branch target is computed speculatively here and parked in ALUOut.
        ctrl_o.alusrca = SRCA_PC;
        ctrl_o.alusrcb = SRCB_SIMM_SH2;
        ctrl_o.aluop   = ALUOP_ADD;
        case (op_i)
          OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LUI,
          OP_LI, OP_BLT, OP_LW, OP_SW: ctrl_o.illegal = 1'b0;
          default:                     ctrl_o.illegal = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alusrca = SRCA_RS;
        ctrl_o.alusrcb = SRCB_SIMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_RTEXE: begin
        ctrl_o.alusrca = SRCA_RS;
        ctrl_o.alusrcb = SRCB_B;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 1'b1;
      end
      S_BEQ, S_BLT: begin
        ctrl_o.alusrca = SRCA_RS;
        ctrl_o.alusrcb = SRCB_B;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.branch  = (state_i == S_BEQ);
        ctrl_o.blt     = (state_i == S_BLT);
      end
      S_IMMEX: begin
        ctrl_o.alusrca = SRCA_ZERO;
        ctrl_o.alusrcb = (op_i == OP_LUI) ? SRCB_IMM_HI : SRCB_SIMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_IMMWB: ctrl_o.regwrite = 1'b1;
      S_JUMP: begin
        ctrl_o.pcsrc   = PCSRC_JUMP;
        ctrl_o.pcwrite = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style main controller: state register and next-state logic,
// with memory-side write strobes held back until memready when MEMWAIT=1.
module mc_controller
  import mc_pkg::*;
#(
  parameter bit MEMWAIT = 1'b0,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               memready,
  output logic               pcwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               memwrite,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               branch,
  output logic               blt,
  output logic [1:0]         alusrca,
  output logic [2:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               illegal,
  output logic [3:0]         state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   memOk;
  logic   memGate;

  assign memOk = MEMWAIT ? memready : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (memOk) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_RTEXE;
          OP_BEQ:         state_d = S_BEQ;
          OP_BLT:         state_d = S_BLT;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_LUI, OP_LI:  state_d = S_IMMEX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (memOk) state_d = S_MEMWB;
      S_MEMWR:  if (memOk) state_d = S_FETCH;
      S_RTEXE:  state_d = S_ALUWB;
      S_ADDIEX, S_IMMEX: state_d = S_IMMWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_BLT, S_IMMWB, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state_i (state_q),
    .op_i    (op),
    .ctrl_o  (ctrl)
  );

  // Only the memory-transfer states wait on memready; JUMP's pcwrite is never held.
  assign memGate = ((state_q == S_FETCH) || (state_q == S_MEMWR)) ? memOk : 1'b1;

  // Strobes are forced low while reset is held, even though the state already reads FETCH.
  assign pcwrite  = reset & memGate & ctrl.pcwrite;
  assign irwrite  = reset & memGate & ctrl.irwrite;
  assign memwrite = reset & memGate & ctrl.memwrite;
  assign regwrite = reset & ctrl.regwrite;
  assign illegal  = reset & ctrl.illegal;

  assign iord     = ctrl.iord;
  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign branch   = ctrl.branch;
  assign blt      = ctrl.blt;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign pcsrc    = ctrl.pcsrc;
  assign state    = state_q;

  always_comb begin
    aluop      = '0;
    aluop[1:0] = ctrl.aluop;
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: one instance with MEMWAIT=1 and one with MEMWAIT=0,
// checked cycle by cycle against an instruction-level reference model.
module tb_mc_controller;
  import mc_pkg::*;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       branch;
    logic       blt;
    logic [1:0] alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
    logic [3:0] state;
  } obs_t;

  logic       clk = 1'b0;
  logic       resetN;
  logic [5:0] op;
  logic       memready1;
  logic       memready0;

  logic       pw1, iw1, rw1, mw1, iord1, mtr1, rd1, br1, blt1, ill1;
  logic [1:0] srca1, pcsrc1, aluop1;
  logic [2:0] srcb1;
  logic [3:0] st1;
  logic       pw0, iw0, rw0, mw0, iord0, mtr0, rd0, br0, blt0, ill0;
  logic [1:0] srca0, pcsrc0, aluop0;
  logic [2:0] srcb0;
  logic [3:0] st0;
  obs_t       obs1, obs0;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  mc_controller #(.MEMWAIT(1'b1), .ALUOP_W(2)) dut1 (
    .clk(clk), .reset(resetN), .op(op), .memready(memready1),
    .pcwrite(pw1), .irwrite(iw1), .regwrite(rw1), .memwrite(mw1), .iord(iord1),
    .memtoreg(mtr1), .regdst(rd1), .branch(br1), .blt(blt1), .alusrca(srca1),
    .alusrcb(srcb1), .pcsrc(pcsrc1), .aluop(aluop1), .illegal(ill1), .state(st1)
  );

  mc_controller #(.MEMWAIT(1'b0), .ALUOP_W(2)) dut0 (
    .clk(clk), .reset(resetN), .op(op), .memready(memready0),
    .pcwrite(pw0), .irwrite(iw0), .regwrite(rw0), .memwrite(mw0), .iord(iord0),
    .memtoreg(mtr0), .regdst(rd0), .branch(br0), .blt(blt0), .alusrca(srca0),
    .alusrcb(srcb0), .pcsrc(pcsrc0), .aluop(aluop0), .illegal(ill0), .state(st0)
  );

  assign obs1 = {pw1, iw1, rw1, mw1, iord1, mtr1, rd1, br1, blt1, srca1, srcb1,
                 pcsrc1, aluop1, ill1, st1};
  assign obs0 = {pw0, iw0, rw0, mw0, iord0, mtr0, rd0, br0, blt0, srca0, srcb0,
                 pcsrc0, aluop0, ill0, st0};

  function automatic logic isSupported(input logic [5:0] iop);
    case (iop)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b011111,
      6'b001000, 6'b001111, 6'b010001, 6'b000010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic obs_t expectFor(input state_e s, input logic [5:0] iop, input logic memOk);
    obs_t e;
    e = '0;
    e.state = s;
    case (s)
      S_FETCH:  begin e.alusrcb = 3'b001; e.pcwrite = memOk; e.irwrite = memOk; end
      S_DECODE: begin e.alusrcb = 3'b011; e.illegal = !isSupported(iop); end
      S_MEMADR: begin e.alusrca = 2'b01; e.alusrcb = 3'b010; end
      S_MEMRD:  e.iord = 1'b1;
      S_MEMWB:  begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
      S_MEMWR:  begin e.iord = 1'b1; e.memwrite = memOk; end
      S_RTEXE:  begin e.alusrca = 2'b01; e.aluop = 2'b10; end
      S_ALUWB:  begin e.regwrite = 1'b1; e.regdst = 1'b1; end
      S_BEQ:    begin e.alusrca = 2'b01; e.aluop = 2'b01; e.pcsrc = 2'b01; e.branch = 1'b1; end
      S_BLT:    begin e.alusrca = 2'b01; e.aluop = 2'b01; e.pcsrc = 2'b01; e.blt = 1'b1; end
      S_ADDIEX: begin e.alusrca = 2'b01; e.alusrcb = 3'b010; end
      S_IMMEX:  begin
        e.alusrca = 2'b10;
        e.alusrcb = (iop == 6'b001111) ? 3'b100 : 3'b010;
      end
      S_IMMWB:  e.regwrite = 1'b1;
      S_JUMP:   begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; end
      default:  ;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH with memready high on the waiting instance;
  // op is scrambled in every state that must ignore it.
  task automatic runInstr(input logic [5:0] iop);
    state_e seq[$];
    obs_t   exp;
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    case (iop)
      6'b100011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMRD); seq.push_back(S_MEMWB); end
      6'b101011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWR); end
      6'b000000: begin seq.push_back(S_RTEXE); seq.push_back(S_ALUWB); end
      6'b000100: seq.push_back(S_BEQ);
      6'b011111: seq.push_back(S_BLT);
      6'b001000: begin seq.push_back(S_ADDIEX); seq.push_back(S_IMMWB); end
      6'b001111, 6'b010001: begin seq.push_back(S_IMMEX); seq.push_back(S_IMMWB); end
      6'b000010: seq.push_back(S_JUMP);
      default: ;
    endcase
    foreach (seq[i]) begin
      if (seq[i] == S_DECODE || seq[i] == S_MEMADR || seq[i] == S_IMMEX) op = iop;
      else op = 6'($urandom);
      memready1 = 1'b1;
      memready0 = 1'($urandom);
      #1;
      exp = expectFor(seq[i], iop, 1'b1);
      nChecks++;
      if (obs1 !== exp) begin
        nFail++;
        $display("FAIL instr op=%b %s memwait1: got %h want %h", iop, seq[i].name(), obs1, exp);
      end
      nChecks++;
      if (obs0 !== exp) begin
        nFail++;
        $display("FAIL instr op=%b %s memwait0: got %h want %h", iop, seq[i].name(), obs0, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetStrobes(input string tag);
    nChecks++;
    if ({st1, pw1, iw1, mw1, rw1, ill1} !== {S_FETCH, 5'b0}) begin
      nFail++;
      $display("FAIL %s memwait1 state/strobes: got %h want %h", tag,
               {st1, pw1, iw1, mw1, rw1, ill1}, {S_FETCH, 5'b0});
    end
    nChecks++;
    if ({st0, pw0, iw0, mw0, rw0, ill0} !== {S_FETCH, 5'b0}) begin
      nFail++;
      $display("FAIL %s memwait0 state/strobes: got %h want %h", tag,
               {st0, pw0, iw0, mw0, rw0, ill0}, {S_FETCH, 5'b0});
    end
  endtask

  task automatic releaseReset();
    resetN    = 1'b1;
    memready1 = 1'b1;
    #1;
    nChecks++;
    if (obs1 !== expectFor(S_FETCH, 6'd0, 1'b1)) begin
      nFail++;
      $display("FAIL release memwait1: got %h want %h", obs1, expectFor(S_FETCH, 6'd0, 1'b1));
    end
    nChecks++;
    if (obs0 !== expectFor(S_FETCH, 6'd0, 1'b1)) begin
      nFail++;
      $display("FAIL release memwait0: got %h want %h", obs0, expectFor(S_FETCH, 6'd0, 1'b1));
    end
  endtask

  task automatic test_reset();
    resetN    = 1'b1;
    op        = 6'b100011;
    memready1 = 1'b1;
    memready0 = 1'b1;
    #2 resetN = 1'b0;
    #1 checkResetStrobes("reset_async");
    tick();
    tick();
    checkResetStrobes("reset_held");
    releaseReset();
  endtask

  task automatic test_directed();
    runInstr(6'b100011);
    runInstr(6'b001111);
    runInstr(6'b011111);
    runInstr(6'b111111);
    runInstr(6'b101011);
    runInstr(6'b000010);
  endtask

  task automatic test_random();
    logic [5:0] legal [9];
    logic [5:0] pick;
    legal = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b011111,
              6'b001000, 6'b001111, 6'b010001, 6'b000010};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(7) == 0) pick = 6'($urandom);
      else pick = legal[$urandom_range(8)];
      runInstr(pick);
    end
  endtask

  task automatic test_memwait();
    op        = 6'b101011;
    memready1 = 1'b0;
    #1;
    nChecks++;
    if ({st1, pw1, iw1} !== {S_FETCH, 2'b00}) begin
      nFail++;
      $display("FAIL fetch_stall: got %h want %h", {st1, pw1, iw1}, {S_FETCH, 2'b00});
    end
    tick();
    memready1 = 1'b1;
    #1;
    nChecks++;
    if ({st1, pw1, iw1} !== {S_FETCH, 2'b11}) begin
      nFail++;
      $display("FAIL fetch_ready: got %h want %h", {st1, pw1, iw1}, {S_FETCH, 2'b11});
    end
    tick();
    tick();
    tick();
    memready1 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      nChecks++;
      if ({st1, mw1, iord1} !== {S_MEMWR, 2'b01}) begin
        nFail++;
        $display("FAIL memwr_stall%0d: got %h want %h", c, {st1, mw1, iord1}, {S_MEMWR, 2'b01});
      end
      tick();
    end
    memready1 = 1'b1;
    #1;
    nChecks++;
    if ({st1, mw1} !== {S_MEMWR, 1'b1}) begin
      nFail++;
      $display("FAIL memwr_ready: got %h want %h", {st1, mw1}, {S_MEMWR, 1'b1});
    end
    tick();
    nChecks++;
    if ({st1, mw1} !== {S_FETCH, 1'b0}) begin
      nFail++;
      $display("FAIL memwr_exit: got %h want %h", {st1, mw1}, {S_FETCH, 1'b0});
    end
  endtask

  task automatic test_reset_mid_memwr();
    op        = 6'b101011;
    memready1 = 1'b1;
    tick();
    tick();
    tick();
    memready1 = 1'b1;
    #1;
    nChecks++;
    if ({st1, mw1} !== {S_MEMWR, 1'b1}) begin
      nFail++;
      $display("FAIL pre_reset_memwr: got %h want %h", {st1, mw1}, {S_MEMWR, 1'b1});
    end
    #1 resetN = 1'b0;
    #1;
    nChecks++;
    if ({st1, mw1, pw1, iw1} !== {S_FETCH, 3'b000}) begin
      nFail++;
      $display("FAIL reset_mid_memwr: got %h want %h", {st1, mw1, pw1, iw1}, {S_FETCH, 3'b000});
    end
    tick();
    checkResetStrobes("reset_mid_held");
    releaseReset();
    runInstr(6'b000000);
    runInstr(6'b100011);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_memwait();
    test_reset_mid_memwr();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter MEMWAIT, default 0: 1 = FETCH/MEMRD/MEMWR stall until memready; 0 = memready ignored, treated as 1.
REQ-002 Parameter ALUOP_W, default 2: width of aluop (min 2).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 op  in  6  opcode of instruction register.
REQ-006 memready  in  1  memory transfer completes this cycle.
REQ-007 pcwrite, irwrite, regwrite, memwrite, iord, memtoreg, regdst, branch, blt  out  1 each  datapath strobes/selects.
REQ-008 alusrca  out  2  00 PC, 01 A (rs), 10 zero.
REQ-009 alusrcb  out  3  000 B, 001 const 4, 010 SignImm, 011 SignImm<<2, 100 Imm<<16.
REQ-010 pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target.
REQ-011 aluop  out  ALUOP_W  00 add, 01 sub, 10 funct-decoded; upper bits 0.
REQ-012 illegal  out  1  one-cycle pulse on unsupported opcode.
REQ-013 state  out  4  current state encoding, debug only.

Function
REQ-014 Outputs SHALL be Moore (decoded from state only), except pcwrite/irwrite/memwrite gated by memready when MEMWAIT=1.
REQ-015 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, ALUWB, BEQ, BLT, ADDIEX, IMMEX, IMMWB, JUMP.
REQ-016 FETCH: iord=0, alusrca=00, alusrcb=001, aluop=00, pcsrc=00, irwrite=pcwrite=1; -> DECODE when memready, else hold.
REQ-017 DECODE: alusrca=00, alusrcb=011, aluop=00 (branch target to ALUOut); next by op: 100011/101011 -> MEMADR, 000000 -> RTEXE, 000100 -> BEQ, 011111 -> BLT, 001000 -> ADDIEX, 001111/010001 -> IMMEX, 000010 -> JUMP, other -> FETCH with illegal=1.
REQ-018 MEMADR: alusrca=01, alusrcb=010, aluop=00; LW -> MEMRD, SW -> MEMWR.
REQ-019 MEMRD: iord=1; -> MEMWB when memready, else hold.
REQ-020 MEMWB: regwrite=1, memtoreg=1, regdst=0; -> FETCH.
REQ-021 MEMWR: iord=1, memwrite=1; -> FETCH when memready, else hold.
REQ-022 RTEXE: alusrca=01, alusrcb=000, aluop=10; -> ALUWB.
REQ-023 ALUWB: regwrite=1, regdst=1, memtoreg=0; -> FETCH.
REQ-024 BEQ: alusrca=01, alusrcb=000, aluop=01, pcsrc=01, branch=1; -> FETCH.
REQ-025 BLT: as BEQ but blt=1, branch=0; -> FETCH.
REQ-026 ADDIEX: alusrca=01, alusrcb=010, aluop=00; -> IMMWB.
REQ-027 IMMEX: alusrca=10, aluop=00; alusrcb=100 for LUI (001111), 010 for LI (010001); -> IMMWB.
REQ-028 IMMWB: regwrite=1, regdst=0, memtoreg=0; -> FETCH.
REQ-029 JUMP: pcsrc=10, pcwrite=1; -> FETCH.
REQ-030 Instruction latency: J 3, BEQ/BLT 3, R/ADDI/LUI/LI 4, SW 4, LW 5 cycles (MEMWAIT=0 or memready constantly 1).
REQ-031 Strobes not listed for a state SHALL be 0; unlisted selects SHALL be 0.
REQ-032 op SHALL be sampled only in DECODE and MEMADR/IMMEX; changes elsewhere have no effect.

Reset
REQ-033 reset=0 SHALL force state=FETCH asynchronously; illegal=0; all strobes SHALL reflect FETCH decode only after reset deasserts (during reset pcwrite/irwrite/memwrite/regwrite=0).
REQ-034 Reset mid-instruction (e.g. in MEMWR) SHALL abandon it with no further write strobe.

Structure
REQ-035 Shared package mc_pkg SHALL hold state enum, opcode constants (incl. LUI 001111, LI 010001, BLT 011111) and alusrca/alusrcb/pcsrc/aluop encodings.
REQ-036 One sub-module, mc_outdec (combinational state -> controls decode), is natural; next-state logic stays in mc_controller.

Verification
REQ-037 Reset release, op=100011, memready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-038 MEMWAIT=1, op=101011, memready low 3 cycles in MEMWR -> memwrite asserted only in the cycle memready=1; hold in MEMWR until then.
REQ-039 op=001111 -> IMMEX shows alusrca=10, alusrcb=100; IMMWB regwrite=1, regdst=0.
REQ-040 op=011111 -> BLT state: blt=1, branch=0, aluop=01, pcsrc=01; back to FETCH next cycle.
REQ-041 op=111111 -> illegal=1 for exactly one cycle in DECODE, no regwrite/memwrite, next state FETCH.
REQ-042 reset asserted asynchronously mid-MEMWR -> state=FETCH before next clk edge, memwrite=0.
